// File: rtl/isr_prefetch_queue_if.sv
// -----------------------------------------------------------------------------
// isr_prefetch_queue_if
//
// Groups the fetch-side and decoder-side signals of the instruction prefetch
// queue. The parameters must match those of the queue instance it connects to.
//
//   master : the fetch/decode side. Drives m_bus, MIS, ADV and FLUSH and reads
//            the queue status.
//   slave  : the queue itself.
//
// Signals
//   m_bus      memory data bus carrying the fetched instruction word
//   MIS        capture strobe: write m_bus into the queue this edge
//   ADV        decoder consumed the head word: pop this edge
//   FLUSH      discard all entries this edge (branch / interrupt / RIT)
//   ISR_out    head word, 0 when empty
//   ISR_valid  head word present
//   ISR_next   second word, 0 when fewer than two entries
//   next_valid at least two entries
//   OP         opcode field, top OPW bits of ISR_out
//   count      number of valid entries
//   full       count == DEPTH
//   empty      count == 0
//   ovf        one-cycle pulse: MIS dropped because the queue was full
//   udf        one-cycle pulse: ADV while empty
// -----------------------------------------------------------------------------
interface isr_prefetch_queue_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int OPW   = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] m_bus;
    logic             MIS;
    logic             ADV;
    logic             FLUSH;

    logic [WIDTH-1:0] ISR_out;
    logic             ISR_valid;
    logic [WIDTH-1:0] ISR_next;
    logic             next_valid;
    logic [OPW-1:0]   OP;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             ovf;
    logic             udf;

    modport master (
        output m_bus, MIS, ADV, FLUSH,
        input  ISR_out, ISR_valid, ISR_next, next_valid, OP,
               count, full, empty, ovf, udf
    );

    modport slave (
        input  m_bus, MIS, ADV, FLUSH,
        output ISR_out, ISR_valid, ISR_next, next_valid, OP,
               count, full, empty, ovf, udf
    );
endinterface

// File: rtl/isr_prefetch_queue.sv
// -----------------------------------------------------------------------------
// isr_prefetch_queue
//
// Instruction prefetch queue sitting in front of the decoder. Fetched words are
// captured from the memory bus on each MIS strobe into a circular FIFO of DEPTH
// entries. The decoder sees the head word (ISR_out) and the word after it
// (ISR_next, for two-word instructions), consumes words with ADV, and a branch,
// interrupt or RIT discards the queue with FLUSH. With DEPTH=1 and OVERWRITE=1
// it behaves like the original single-word instruction register.
//
// Parameters
//   WIDTH      instruction word width
//   DEPTH      number of entries, any integer >= 1 (need not be a power of 2)
//   OPW        opcode field width, taken from the top of the head word
//   OVERWRITE  1: MIS while full replaces the newest entry
//              0: MIS while full is dropped and flagged on ovf
//
// Ports
//   CLK  system clock, rising edge
//   CLR  asynchronous active-high reset
//   q    isr_prefetch_queue_if.slave (bus, strobes, head/next words, status)
//
// Per-edge priority: FLUSH > MIS+ADV (not empty) > MIS > ADV.
// -----------------------------------------------------------------------------
module isr_prefetch_queue #(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 4,
    parameter int OPW       = 4,
    parameter int OVERWRITE = 0
) (
    input  logic                  CLK,
    input  logic                  CLR,
    isr_prefetch_queue_if.slave   q
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);

    // -------------------------------------------------------------------------
    // Pointer arithmetic: explicit wrap so non-power-of-two depths work.
    // -------------------------------------------------------------------------
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    function automatic logic [PW-1:0] ptr_dec(input logic [PW-1:0] p);
        return (p == '0) ? LAST_PTR : p - PW'(1);
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [CW-1:0]    count_reg,  count_next;
    logic             ovf_reg,    ovf_next;
    logic             udf_reg,    udf_next;

    // Single write port into the entry array.
    logic             wr_en;
    logic [PW-1:0]    wr_addr;

    logic             is_empty;
    logic             is_full;

    assign is_empty = (count_reg == '0);
    assign is_full  = (count_reg == FULL_CNT);

    // -------------------------------------------------------------------------
    // Next-state decision
    // -------------------------------------------------------------------------
    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;
        ovf_next    = 1'b0;
        udf_next    = 1'b0;
        wr_en       = 1'b0;
        wr_addr     = wr_ptr_reg;

        if (q.FLUSH) begin
            // Discard everything by snapping the read pointer onto the write
            // pointer. A simultaneous fetch is the branch target, so it lands
            // at wr_ptr and becomes the new head. ADV is meaningless here.
            rd_ptr_next = wr_ptr_reg;
            count_next  = '0;
            if (q.MIS) begin
                wr_en       = 1'b1;
                wr_ptr_next = ptr_inc(wr_ptr_reg);
                count_next  = ONE_CNT;
            end
        end else if (q.MIS && q.ADV && !is_empty) begin
            // Push and pop together. When full, wr_ptr == rd_ptr, so the word
            // written is the one being popped; nothing visible is lost. For
            // DEPTH=1 both pointers stay at 0 and the word simply replaces.
            wr_en       = 1'b1;
            wr_ptr_next = ptr_inc(wr_ptr_reg);
            rd_ptr_next = ptr_inc(rd_ptr_reg);
        end else if (q.MIS) begin
            if (!is_full) begin
                wr_en       = 1'b1;
                wr_ptr_next = ptr_inc(wr_ptr_reg);
                count_next  = count_reg + ONE_CNT;
                // Only reachable with ADV when the queue is empty.
                udf_next    = q.ADV;
            end else if (OVERWRITE != 0) begin
                // Replace the newest entry, leaving pointers and count alone.
                wr_en   = 1'b1;
                wr_addr = ptr_dec(wr_ptr_reg);
            end else begin
                ovf_next = 1'b1;
            end
        end else if (q.ADV) begin
            if (!is_empty) begin
                rd_ptr_next = ptr_inc(rd_ptr_reg);
                count_next  = count_reg - ONE_CNT;
            end else begin
                udf_next = 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Control registers
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            ovf_reg    <= 1'b0;
            udf_reg    <= 1'b0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
            ovf_reg    <= ovf_next;
            udf_reg    <= udf_next;
        end
    end

    // -------------------------------------------------------------------------
    // Entry storage: one register per slot with a decoded write enable. The
    // head and next words are read combinationally, so these stay flops.
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge CLK or posedge CLR) begin
                if (CLR) begin
                    mem_reg[gi] <= '0;
                end else if (wr_en && (wr_addr == PW'(gi))) begin
                    mem_reg[gi] <= q.m_bus;
                end
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Decoder-facing outputs. Popped slots keep stale data, so every read is
    // gated by the matching valid flag.
    // -------------------------------------------------------------------------
    logic             head_valid;
    logic [WIDTH-1:0] head_word;

    assign head_valid  = !is_empty;
    assign head_word   = head_valid ? mem_reg[rd_ptr_reg] : '0;

    assign q.ISR_valid = head_valid;
    assign q.ISR_out   = head_word;
    assign q.OP        = head_word[WIDTH-1 -: OPW];
    assign q.count     = count_reg;
    assign q.full      = is_full;
    assign q.empty     = is_empty;
    assign q.ovf       = ovf_reg;
    assign q.udf       = udf_reg;

    generate
        if (DEPTH == 1) begin : g_no_next
            assign q.next_valid = 1'b0;
            assign q.ISR_next   = '0;
        end else begin : g_next
            logic [PW-1:0] next_ptr;
            logic          second_valid;

            assign next_ptr     = ptr_inc(rd_ptr_reg);
            assign second_valid = (count_reg >= CW'(2));
            assign q.next_valid = second_valid;
            assign q.ISR_next   = second_valid ? mem_reg[next_ptr] : '0;
        end
    endgenerate

endmodule
